// File: rtl/rc4_ksa_pkg.sv
// Shared RC4 types and constants for the key-scheduling and decrypt stages.
package rc4_pkg;

    localparam int S_SIZE        = 256;
    localparam int RC4_KEY_BYTES = 3;
    localparam int RC4_READ_WAIT = 2;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        ADDR_I,
        WAIT_I,
        CAP_I,
        ADDR_J,
        WAIT_J,
        CAP_J,
        WR_I,
        WR_J,
        DONE
    } ksa_state_t;

endpackage

// File: rtl/rc4_ksa_if.sv
// Single-port S-box RAM bus: the stage owning the RAM is the master.
interface rc4_ksa_if;
    logic [7:0] address;
    logic [7:0] data;
    logic       wren;
    logic [7:0] q;

    modport master (output address, output data, output wren, input q);
    modport slave  (input address, input data, input wren, output q);
endinterface

// File: rtl/rc4_ksa_key_byte_sel.sv
// Selects key[kidx] (MSB-first byte order) with a wrapping byte index.
module rc4_key_byte_sel
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = RC4_KEY_BYTES
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   advance,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic [7:0]             key_byte
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    logic [KW-1:0] kidx;

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            kidx <= '0;
        end else if (advance) begin
            kidx <= (kidx == KW'(KEY_BYTES - 1)) ? '0 : kidx + 1'b1;
        end
    end

    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx == KW'(k)) key_byte = secret_key[8*(KEY_BYTES-k)-1 -: 8];
        end
    end

endmodule

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling stage driving the S-box RAM port.
// Define RC4_KSA_INIT_EN to fill S with the identity before permuting.
module rc4_ksa
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = RC4_KEY_BYTES,
    parameter int READ_WAIT = RC4_READ_WAIT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   finish,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    rc4_ksa_if.master              ram
);

    // state  | meaning
    // IDLE   | waiting for start
    // INIT   | writing S[i]=i (RC4_KSA_INIT_EN only)
    // ADDR_I | present address i
    // WAIT_I | RAM read latency for S[i]
    // CAP_I  | capture S[i], update j
    // ADDR_J | present address j
    // WAIT_J | RAM read latency for S[j]
    // CAP_J  | capture S[j]
    // WR_I   | S[i] <= S[j]
    // WR_J   | S[j] <= S[i], advance or finish
    // DONE   | finish high until start drops

    localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    ksa_state_t    state, state_nxt;
    logic [7:0]    i, i_nxt, j, j_nxt;
    logic [7:0]    si, si_nxt, sj, sj_nxt;
    logic [WW-1:0] wcnt, wcnt_nxt;
    logic [7:0]    key_byte;
    logic          kclr, kadv;
    logic [7:0]    addr_c, data_c;
    logic          wren_c, finish_c;

    rc4_key_byte_sel #(.KEY_BYTES(KEY_BYTES)) u_key_sel (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (kclr),
        .advance    (kadv),
        .secret_key (secret_key),
        .key_byte   (key_byte)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            si    <= '0;
            sj    <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            i     <= i_nxt;
            j     <= j_nxt;
            si    <= si_nxt;
            sj    <= sj_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        i_nxt     = i;
        j_nxt     = j;
        si_nxt    = si;
        sj_nxt    = sj;
        wcnt_nxt  = wcnt;
        kclr      = 1'b0;
        kadv      = 1'b0;
        addr_c    = '0;
        data_c    = '0;
        wren_c    = 1'b0;
        finish_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    i_nxt = '0;
                    j_nxt = '0;
                    kclr  = 1'b1;
`ifdef RC4_KSA_INIT_EN
                    state_nxt = INIT;
`else
                    state_nxt = ADDR_I;
`endif
                end
            end
`ifdef RC4_KSA_INIT_EN
            // i doubles as the fill counter and wraps back to 0 for the KSA
            INIT: begin
                addr_c = i;
                data_c = i;
                wren_c = 1'b1;
                i_nxt  = i + 8'd1;
                if (i == 8'hFF) state_nxt = ADDR_I;
            end
`endif
            ADDR_I: begin
                addr_c    = i;
                wcnt_nxt  = WW'(READ_WAIT - 1);
                state_nxt = WAIT_I;
            end
            WAIT_I: begin
                addr_c = i;
                if (wcnt == '0) state_nxt = CAP_I;
                else            wcnt_nxt  = wcnt - 1'b1;
            end
            CAP_I: begin
                addr_c    = i;
                si_nxt    = ram.q;
                j_nxt     = j + ram.q + key_byte;
                state_nxt = ADDR_J;
            end
            ADDR_J: begin
                addr_c    = j;
                wcnt_nxt  = WW'(READ_WAIT - 1);
                state_nxt = WAIT_J;
            end
            WAIT_J: begin
                addr_c = j;
                if (wcnt == '0) state_nxt = CAP_J;
                else            wcnt_nxt  = wcnt - 1'b1;
            end
            CAP_J: begin
                addr_c    = j;
                sj_nxt    = ram.q;
                state_nxt = WR_I;
            end
            WR_I: begin
                addr_c    = i;
                data_c    = sj;
                wren_c    = 1'b1;
                state_nxt = WR_J;
            end
            WR_J: begin
                addr_c = j;
                data_c = si;
                wren_c = 1'b1;
                if (i == 8'hFF) begin
                    state_nxt = DONE;
                end else begin
                    i_nxt     = i + 8'd1;
                    kadv      = 1'b1;
                    state_nxt = ADDR_I;
                end
            end
            DONE: begin
                finish_c = 1'b1;
                if (!start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ram.address = addr_c;
    assign ram.data    = data_c;
    assign ram.wren    = wren_c;
    assign finish      = finish_c;

endmodule

// File: tb/tb_rc4_ksa.sv
// Self-checking bench for rc4_ksa with a behavioural S-box RAM and software KSA model.
module tb_rc4_ksa;

    localparam int KB = 3;
`ifdef RC4_KSA_INIT_EN
    localparam int INIT_CYC = 256;
`else
    localparam int INIT_CYC = 0;
`endif
    localparam int RUN   = INIT_CYC + 2560;
    localparam int LIMIT = RUN + 200;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          finish;
    logic [23:0]   secret_key;
    rc4_ksa_if     ram ();

    rc4_ksa #(.KEY_BYTES(KB), .READ_WAIT(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .finish     (finish),
        .secret_key (secret_key),
        .ram        (ram)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [15:0] wlog [$];
    logic [1:0]  preload_mode = 2'd0;
    int          ref_s [256];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Synchronous RAM, one cycle read latency; preload requests serviced on a clock edge
    always @(posedge clk) begin
        if (ram.wren) begin
            mem[ram.address] <= ram.data;
            wlog.push_back({ram.address, ram.data});
        end
        ram.q <= mem[ram.address];
        if (preload_mode == 2'd1) for (int n = 0; n < 256; n++) mem[n] <= 8'(n);
        if (preload_mode == 2'd2) for (int n = 0; n < 256; n++) mem[n] <= 8'($urandom);
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int key_byte(input logic [23:0] key, input int k);
        return int'((key >> (8 * (KB - 1 - k))) & 24'hFF);
    endfunction

    // Reference KSA from the identity permutation, for the first nit iterations
    function automatic void model_ksa(input logic [23:0] key, input int nit);
        int jj, t;
        jj = 0;
        for (int n = 0; n < 256; n++) ref_s[n] = n;
        for (int ii = 0; ii < nit; ii++) begin
            jj = (jj + ref_s[ii] + key_byte(key, ii % KB)) % 256;
            t = ref_s[ii]; ref_s[ii] = ref_s[jj]; ref_s[jj] = t;
        end
    endfunction

    task automatic preload();
        @(negedge clk);
`ifdef RC4_KSA_INIT_EN
        preload_mode = 2'd2;
`else
        preload_mode = 2'd1;
`endif
        @(negedge clk);
        preload_mode = 2'd0;
    endtask

    task automatic wait_finish(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!finish && cyc < LIMIT);
        check("finish_reached", int'(finish), 1);
    endtask

    task automatic run_key(input logic [23:0] key, output int cyc);
        @(negedge clk);
        secret_key = key;
        start = 1'b1;
        @(posedge clk);
        wait_finish(cyc);
    endtask

    task automatic compare_all(input string name, input logic [23:0] key);
        int bad;
        bad = 0;
        model_ksa(key, 256);
        for (int n = 0; n < 256; n++) if (int'(mem[n]) != ref_s[n]) bad++;
        check(name, bad, 0);
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check("finish_drop", int'(finish), 0);
    endtask

    task automatic abort();
        @(negedge clk);
        reset_n = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic [23:0] key;
        int          nit;
        int          idx;
        int          exp;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int cyc, base, bad;
        logic [23:0] rkey;

        vecs[0] = '{24'h000000, 3, 0, 0};
        vecs[1] = '{24'h000000, 3, 1, 1};
        vecs[2] = '{24'h000000, 3, 2, 3};
        vecs[3] = '{24'h000000, 3, 3, 2};
        vecs[4] = '{24'h000001, 3, 2, 4};
        vecs[5] = '{24'h000001, 3, 4, 2};
        vecs[6] = '{24'h000001, 3, 3, 3};

        reset_n = 1'b0;
        start = 1'b0;
        secret_key = '0;
        preload();

        // Reset held with start high, then release and time a full run
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_finish", int'(finish), 0);
        check("rst_wren", int'(ram.wren), 0);
        check("rst_address", int'(ram.address), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        wait_finish(cyc);
        check("run_len_key0", cyc, RUN);
        compare_all("s_key0", 24'h000000);

        // Holding start keeps DONE with no RAM writes
        base = wlog.size();
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (finish !== 1'b1) bad++;
        end
        check("done_hold", bad, 0);
        check("done_no_writes", wlog.size() - base, 0);
        drop_start();

        // Early-iteration S values, then abort the run
        foreach (vecs[v]) begin
            preload();
            @(negedge clk);
            secret_key = vecs[v].key;
            start = 1'b1;
            @(posedge clk);
            repeat (INIT_CYC + 10 * vecs[v].nit) @(posedge clk);
            #1;
            check($sformatf("vec%0d_s%0d", v, vecs[v].idx), int'(mem[vecs[v].idx]), vecs[v].exp);
            abort();
        end

        // i==j at i=1 under key 0: two identical writes to address 1
        preload();
        base = wlog.size() + INIT_CYC;
        @(negedge clk);
        secret_key = 24'h000000;
        start = 1'b1;
        @(posedge clk);
        repeat (INIT_CYC + 20) @(posedge clk);
        #1;
        check("ieqj_writes", wlog.size() - base, 4);
        check("ieqj_wr_i", int'(wlog[base + 2]), 16'h0101);
        check("ieqj_wr_j", int'(wlog[base + 3]), 16'h0101);
        check("ieqj_s1", int'(mem[1]), 1);
        abort();

        // Mid-run reset, then a clean rerun with key 1
        preload();
        @(negedge clk);
        secret_key = 24'h000001;
        start = 1'b1;
        @(posedge clk);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("midrst_wren", int'(ram.wren), 0);
        check("midrst_finish", int'(finish), 0);
        check("midrst_address", int'(ram.address), 0);
        @(negedge clk);
        reset_n = 1'b1;
        preload();
        run_key(24'h000001, cyc);
        check("run_len_key1", cyc, RUN);
        compare_all("s_key1", 24'h000001);
        drop_start();

        // Random keys, back-to-back runs
        for (int r = 0; r < 3; r++) begin
            rkey = 24'($urandom);
            preload();
            run_key(rkey, cyc);
            check($sformatf("run_len_rand%0d", r), cyc, RUN);
            compare_all($sformatf("s_rand%0d", r), rkey);
            drop_start();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
